// File: rtl/pc_sequencer.sv
// Program counter and next-PC selection for the single-cycle MIPS core, with boot, stall, halt and retire count.
// Optional build macro PC_MISALIGN_TRAP_EN redirects misaligned next-PC targets to TRAP_ADDR.
module pc_sequencer #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] TRAP_ADDR  = 32'h0000_0080
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        halt_i,
  input  logic        branch_taken_i,
  input  logic [31:0] endereco_jump_i,
  input  logic        jump_i,
  input  logic [25:0] jump_target_i,
  input  logic        jump_reg_i,
  input  logic [31:0] reg_target_i,
  output logic [31:0] endereco_PC_o,
  output logic [31:0] pc_plus4_o,
  output logic        redirect_o,
  output logic        halted_o,
  output logic [31:0] instr_count_o,
  output logic        misaligned_o
);

  // state   | meaning
  // BOOT    | one settling cycle after reset; PC and count held
  // RUN     | normal fetch; advances when enable_i is high
  // HALTED  | frozen until reset
  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic        redirect_q, redirect_d;
  logic        halted_q, halted_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] next_pc;
  logic        nonseq;

  assign pc_plus4_o = pc_q + 32'd4;

  always_comb begin
    next_pc = pc_plus4_o;
    nonseq  = 1'b0;
    if (jump_reg_i) begin
      next_pc = reg_target_i;
      nonseq  = 1'b1;
    end else if (jump_i) begin
      next_pc = {pc_plus4_o[31:28], jump_target_i, 2'b00};
      nonseq  = 1'b1;
    end else if (branch_taken_i) begin
      next_pc = endereco_jump_i;
      nonseq  = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    redirect_d   = 1'b0;
    halted_d     = halted_q;
    misaligned_d = misaligned_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (enable_i) begin
          count_d = count_q + 32'd1;
          if (halt_i) begin
            state_d  = S_HALTED;
            halted_d = 1'b1;
          end else begin
            pc_d       = next_pc;
            redirect_d = nonseq;
`ifdef PC_MISALIGN_TRAP_EN
            if (next_pc[1:0] != 2'b00) begin
              pc_d         = TRAP_ADDR;
              misaligned_d = 1'b1;
              redirect_d   = 1'b1;
            end
`endif
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_ADDR;
      count_q      <= 32'd0;
      redirect_q   <= 1'b0;
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      redirect_q   <= redirect_d;
      halted_q     <= halted_d;
      misaligned_q <= misaligned_d;
    end
  end

`ifndef PC_MISALIGN_TRAP_EN
  // Trap vector only matters when alignment checking is built in.
  logic unused_trap;
  assign unused_trap = ^TRAP_ADDR;
`endif

  assign endereco_PC_o = pc_q;
  assign instr_count_o = count_q;
  assign redirect_o    = redirect_q;
  assign halted_o      = halted_q;
  assign misaligned_o  = misaligned_q;

endmodule
